request_scheduler: RTL and testbench
====================================

# request_scheduler

Front-end stage of the elevator controller, sitting directly upstream of `Interface`. It synchronizes and debounces the seven raw push-buttons, latches one pending request per floor, and clears a request when the car reports arrival at that floor. It runs a SCAN-style direction state machine and presents `Interface` with a single target floor and a direction.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required to accept a button level change (hardware builds override, e.g. 1_000_000).
- `CNT_W`, default 5: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- `clk` in 1: single system clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset).
- `enable` in 1: 1 enables target issue; 0 freezes direction and suppresses `target_valid`. Latching continues while `enable` is 0.
- `Button1`..`Button4` in 1 each: cab calls for floors 0..3, raw and asynchronous.
- `Button5`..`Button7` in 1 each: hall calls for floors 1..3, raw and asynchronous. A hall call at floor 0 is wired onto `Button1`.
- `Level` in 2: current car floor, driven by `Interface`.
- `arrived` in 1: one-cycle pulse from `Interface` when the doors open at `Level`.
- `pending` out 4: latched requests, bit f = floor f.
- `target` out 2: floor the car should travel to.
- `target_valid` out 1: `target` is meaningful.
- `dir` out 2: 00 IDLE, 01 UP, 10 DOWN.

## Operation
- Each button passes through a 2-flop synchronizer and then a debouncer.
- Debouncer behaviour:
  - The counter resets whenever the synchronized sample equals the current debounced level.
  - Otherwise the counter increments; when it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
  - Pulses shorter than DEBOUNCE_CYCLES samples are ignored.
- A rising edge of a debounced level sets that floor's request. Cab and hall calls for the same floor OR into one bit. Falling edges have no effect.
- Clearing: `arrived`=1 clears `pending[Level]` at the same edge. If a set and a clear hit the same floor on the same edge, the clear wins. Sets for other floors proceed normally.
- Direction state machine:
  - IDLE to UP: any request above `Level`. Upward requests take priority when requests exist both above and below.
  - IDLE to DOWN: requests exist only below `Level`.
  - UP: target = lowest pending floor above `Level`. If none exists and requests exist below, go to DOWN. If `pending` is empty, go to IDLE.
  - DOWN: symmetric to UP, with target = highest pending floor below `Level`.
  - IDLE with only `pending[Level]` set: target = `Level`, `target_valid`=1, `dir` stays IDLE.
- `target_valid` = `enable` AND (`pending` != 0). `target` holds its last value when invalid.
- While `enable`=0, the state register holds its value.
- `Level` values are taken as-is. No range check is needed because 2 bits cover the 4 floors.

## Timing
- Reset (asynchronous, active-low): `pending`=0, `target`=0, `target_valid`=0, `dir`=IDLE. Synchronizers, debounced levels and counters all go to 0.
- A button held high from cycle 0 sets its `pending` bit visible after exactly DEBOUNCE_CYCLES+3 rising edges: 2 sync, DEBOUNCE_CYCLES debounce, 1 edge-detect/latch.
- `target`, `dir` and `target_valid` are registered. They reflect `pending`/`Level` from the previous cycle, so they are 1 cycle behind `pending`.
- The `arrived` clear is visible on `pending` the next cycle and on `target`/`dir` the cycle after.
- Reset asserted mid-debounce or mid-travel discards all requests immediately. After release, a still-held button re-latches after the full DEBOUNCE_CYCLES+3 delay.

## Structure
- Shared `elevator_pkg` (or `elevator_defs.vh` include) holds:
  - `DIR_IDLE`/`DIR_UP`/`DIR_DOWN` encodings;
  - `NUM_FLOORS`=4 and `FLOOR_W`=2;
  - debounce default. `Interface` uses the same encodings.
- Sub-module `button_debouncer`: synchronizer, counter and debounced level. It is instantiated 7 times.
- Edge detection, the request register and the scheduler FSM live in the top.

## Test plan
- **Single press**: `Button3` held 40 cycles with `Level`=0, `enable`=1 → `pending`=0100 at cycle 19; next cycle `dir`=UP, `target`=2, `target_valid`=1.
- **Glitch reject**: `Button2` high for 10 cycles → `pending` stays 0000 throughout.
- **Arrival clear with simultaneous set**: `pending`=0100, `Level`=2, `arrived` pulse on the same edge as a debounced `Button6` rise (floor 2) → `pending`=0000; `dir` returns to IDLE 1 cycle later.
- **SCAN order**: `Level`=1, `dir`=UP, `pending`=1001 → `target`=3. Then with `Level`=3, `arrived` → `pending`=0001, `dir`=DOWN, `target`=0.
- **Enable gating**: `enable`=0 with `pending`=0010 → `target_valid`=0 and `dir` frozen. `enable` rises → `target_valid`=1 next cycle.
- **Async reset mid-operation**: `reset` low for half a cycle while `pending`=1111 and `dir`=UP → all outputs 0/IDLE immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/request_scheduler_pkg.sv
// rtl/request_scheduler_pkg.sv - shared elevator encodings and sizes
package request_scheduler_pkg;

  localparam int NUM_FLOORS       = 4;
  localparam int FLOOR_W          = 2;
  localparam int DEBOUNCE_DEFAULT = 16;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_t;

endpackage

// File: rtl/request_scheduler_if.sv
// rtl/request_scheduler_if.sv - scheduler <-> car Interface bus
interface request_scheduler_if;
  import request_scheduler_pkg::*;

  logic [FLOOR_W-1:0] Level;
  logic               arrived;
  logic [FLOOR_W-1:0] target;
  logic               target_valid;
  dir_t               dir;

  modport master (
    input  Level,
    input  arrived,
    output target,
    output target_valid,
    output dir
  );

  modport slave (
    output Level,
    output arrived,
    input  target,
    input  target_valid,
    input  dir
  );

endinterface

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - 2-flop synchronizer plus stable-count debouncer
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      // Any sample agreeing with the current level restarts the stability count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/request_scheduler.sv
// rtl/request_scheduler.sv - button debounce, per-floor request latch and SCAN direction FSM
module request_scheduler
  import request_scheduler_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   Button1,
  input  logic                   Button2,
  input  logic                   Button3,
  input  logic                   Button4,
  input  logic                   Button5,
  input  logic                   Button6,
  input  logic                   Button7,
  request_scheduler_if.master    bus,
  output logic [NUM_FLOORS-1:0]  pending
);

  logic [6:0]            raw;
  logic [6:0]            deb;
  logic [6:0]            deb_q;
  logic [6:0]            rise;
  logic [NUM_FLOORS-1:0] set_req;
  logic [NUM_FLOORS-1:0] clr_req;

  assign raw = {Button7, Button6, Button5, Button4, Button3, Button2, Button1};

  for (genvar i = 0; i < 7; i++) begin : g_deb
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .button(raw[i]),
      .level (deb[i])
    );
  end

  // Buttons 1-4 are cab calls for floors 0-3; buttons 5-7 are hall calls for floors 1-3.
  assign rise    = deb & ~deb_q;
  assign set_req = {rise[3] | rise[6], rise[2] | rise[5], rise[1] | rise[4], rise[0]};
  assign clr_req = bus.arrived ? (4'b0001 << bus.Level) : 4'b0000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      deb_q   <= '0;
      pending <= '0;
    end else begin
      deb_q   <= deb;
      pending <= (pending | set_req) & ~clr_req;
    end
  end

  dir_t                  state;
  dir_t                  state_n;
  logic [FLOOR_W-1:0]    target_r;
  logic [FLOOR_W-1:0]    target_n;
  logic                  valid_r;
  logic [NUM_FLOORS-1:0] above;
  logic [NUM_FLOORS-1:0] below;
  logic [FLOOR_W-1:0]    low_above;
  logic [FLOOR_W-1:0]    high_below;
  logic                  here;

  always_comb begin
    above      = '0;
    below      = '0;
    low_above  = '0;
    high_below = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (f > int'(bus.Level)) above[f] = pending[f];
      if (f < int'(bus.Level)) below[f] = pending[f];
    end
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (above[f]) low_above = FLOOR_W'(f);
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (below[f]) high_below = FLOOR_W'(f);
    end
    here = pending[bus.Level];
  end

  always_comb begin
    state_n  = state;
    target_n = target_r;
    unique case (state)
      DIR_IDLE: begin
        if (|above) begin
          state_n  = DIR_UP;
          target_n = low_above;
        end else if (|below) begin
          state_n  = DIR_DOWN;
          target_n = high_below;
        end else if (here) begin
          target_n = bus.Level;
        end
      end
      DIR_UP: begin
        if (|above) begin
          target_n = low_above;
        end else if (|below) begin
          state_n  = DIR_DOWN;
          target_n = high_below;
        end else if (here) begin
          target_n = bus.Level;
        end else begin
          state_n = DIR_IDLE;
        end
      end
      DIR_DOWN: begin
        if (|below) begin
          target_n = high_below;
        end else if (|above) begin
          state_n  = DIR_UP;
          target_n = low_above;
        end else if (here) begin
          target_n = bus.Level;
        end else begin
          state_n = DIR_IDLE;
        end
      end
      default: state_n = DIR_IDLE;
    endcase
    // Disabled: requests still latch but direction and target are frozen.
    if (!enable) begin
      state_n  = state;
      target_n = target_r;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= DIR_IDLE;
      target_r <= '0;
      valid_r  <= 1'b0;
    end else begin
      state    <= state_n;
      target_r <= target_n;
      valid_r  <= enable & (|pending);
    end
  end

  assign bus.dir          = state;
  assign bus.target       = target_r;
  assign bus.target_valid = valid_r;

endmodule

// File: tb/tb_request_scheduler.sv
// tb/tb_request_scheduler.sv - directed table-driven bench for request_scheduler
module tb_request_scheduler;
  import request_scheduler_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b0;
  logic [6:0] btn = '0;
  logic [3:0] pending;

  request_scheduler_if bus();

  request_scheduler #(.DEBOUNCE_CYCLES(16), .CNT_W(5)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .Button1(btn[0]),
    .Button2(btn[1]),
    .Button3(btn[2]),
    .Button4(btn[3]),
    .Button5(btn[4]),
    .Button6(btn[5]),
    .Button7(btn[6]),
    .bus    (bus),
    .pending(pending)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [6:0] btn;
    logic [1:0] lvl;
    logic       arr;
    logic       en;
    int         cyc;
    logic [3:0] p;
    logic [1:0] d;
    logic [1:0] t;
    logic       v;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(input logic [6:0] b, input logic [1:0] l, input logic a,
                              input logic e, input int c, input logic [3:0] p,
                              input logic [1:0] d, input logic [1:0] t, input logic v);
    vec_t r;
    r.btn = b; r.lvl = l; r.arr = a; r.en = e; r.cyc = c;
    r.p = p; r.d = d; r.t = t; r.v = v;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [3:0] p, input logic [1:0] d,
                            input logic [1:0] t, input logic v);
    check({tag, "_pending"}, 32'(pending), 32'(p));
    check({tag, "_dir"}, 32'(bus.dir), 32'(d));
    check({tag, "_target"}, 32'(bus.target), 32'(t));
    check({tag, "_valid"}, 32'(bus.target_valid), 32'(v));
  endtask

  initial begin
    //             btn         lvl a  e  cyc  pend     dir    tgt v
    vecs[0]  = mk(7'b0000000, 2'd0, 0, 1, 20, 4'b0100, 2'b01, 2'd2, 1);
    vecs[1]  = mk(7'b0100000, 2'd2, 0, 1, 18, 4'b0100, 2'b01, 2'd2, 1);
    vecs[2]  = mk(7'b0100000, 2'd2, 1, 1,  1, 4'b0000, 2'b01, 2'd2, 1);
    vecs[3]  = mk(7'b0100000, 2'd2, 0, 1,  1, 4'b0000, 2'b00, 2'd2, 0);
    vecs[4]  = mk(7'b0000000, 2'd1, 0, 1, 20, 4'b0000, 2'b00, 2'd2, 0);
    vecs[5]  = mk(7'b0001001, 2'd1, 0, 1, 19, 4'b1001, 2'b00, 2'd2, 0);
    vecs[6]  = mk(7'b0001001, 2'd1, 0, 1,  1, 4'b1001, 2'b01, 2'd3, 1);
    vecs[7]  = mk(7'b0001001, 2'd3, 1, 1,  1, 4'b0001, 2'b10, 2'd0, 1);
    vecs[8]  = mk(7'b0001001, 2'd3, 0, 1,  1, 4'b0001, 2'b10, 2'd0, 1);
    vecs[9]  = mk(7'b0000000, 2'd0, 1, 1,  1, 4'b0000, 2'b10, 2'd0, 1);
    vecs[10] = mk(7'b0000000, 2'd0, 0, 1, 20, 4'b0000, 2'b00, 2'd0, 0);
    vecs[11] = mk(7'b0000010, 2'd0, 0, 0, 19, 4'b0010, 2'b00, 2'd0, 0);
    vecs[12] = mk(7'b0000010, 2'd0, 0, 0,  5, 4'b0010, 2'b00, 2'd0, 0);
    vecs[13] = mk(7'b0000010, 2'd0, 0, 1,  1, 4'b0010, 2'b01, 2'd1, 1);
    vecs[14] = mk(7'b0000000, 2'd0, 0, 1, 20, 4'b0010, 2'b01, 2'd1, 1);
    vecs[15] = mk(7'b1000000, 2'd0, 0, 1, 15, 4'b0010, 2'b01, 2'd1, 1);
    vecs[16] = mk(7'b0000000, 2'd0, 0, 1, 20, 4'b0010, 2'b01, 2'd1, 1);
    vecs[17] = mk(7'b1000000, 2'd0, 0, 1, 16, 4'b0010, 2'b01, 2'd1, 1);
    vecs[18] = mk(7'b0000000, 2'd0, 0, 1,  3, 4'b1010, 2'b01, 2'd1, 1);
    vecs[19] = mk(7'b0000000, 2'd0, 0, 1, 20, 4'b1010, 2'b01, 2'd1, 1);

    bus.Level   = 2'd0;
    bus.arrived = 1'b0;
    #12;
    check_outs("reset", 4'b0000, 2'b00, 2'd0, 1'b0);
    step(1);
    reset  = 1'b1;
    enable = 1'b1;

    // Pulse shorter than the debounce window never latches.
    btn[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("glitch_hi", 32'(pending), 32'h0);
    end
    btn[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      check("glitch_lo", 32'(pending), 32'h0);
    end

    btn[2] = 1'b1;
    step(18);
    check("press_early", 32'(pending), 32'h0);
    step(1);
    check("press_latch", 32'(pending), 32'h4);
    check("press_dir_lag", 32'(bus.dir), 32'(DIR_IDLE));
    step(1);
    check_outs("press_fsm", 4'b0100, 2'b01, 2'd2, 1'b1);
    step(20);

    for (int i = 0; i < 20; i++) begin
      btn         = vecs[i].btn;
      bus.Level   = vecs[i].lvl;
      bus.arrived = vecs[i].arr;
      enable      = vecs[i].en;
      step(vecs[i].cyc);
      check_outs($sformatf("vec%0d", i), vecs[i].p, vecs[i].d, vecs[i].t, vecs[i].v);
    end
    bus.arrived = 1'b0;

    btn = 7'b0001111;
    step(19);
    check("all_latch", 32'(pending), 32'hF);
    step(1);
    check_outs("all_fsm", 4'b1111, 2'b01, 2'd1, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check_outs("async_rst", 4'b0000, 2'b00, 2'd0, 1'b0);
    #1;
    reset = 1'b1;
    step(18);
    check("relatch_early", 32'(pending), 32'h0);
    step(1);
    check("relatch", 32'(pending), 32'hF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
